bcd_down_timer: RTL and testbench
=================================

// Module: bcd_down_timer
// PURPOSE
//   Multi-digit BCD down counter (countdown timer): counterpart to the decimal up-counter chain.
//   Preloaded with a BCD value, decrements one count per enabled clock, and propagates borrows digit to digit.
//   Flags terminal zero (one-shot) or wraps to all-nines with a borrow pulse (cascade mode).
//   Used for timeouts and display countdowns next to the up-counter blocks.
// PARAMETERS
//   DIGITS  2  number of BCD digits; DOUT/DIN width = 4*DIGITS
//   WRAP    0  0: one-shot, stop at zero; 1: free-run, 0..0 wraps to 9..9 with BOUT pulse
// PORTS
//   CLK    in   1          single clock, all state changes on posedge
//   RST    in   1          synchronous, active-high reset
//   LOAD   in   1          load DIN (all digits must be 0-9)
//   DIN    in   4*DIGITS   BCD preload value, digit 0 = DIN[3:0]
//   START  in   1          begin countdown from current DOUT
//   EN     in   1          count enable / tick; one decrement per cycle sampled high in RUN
//   DOUT   out  4*DIGITS   current BCD count (registered)
//   BOUT   out  1          borrow-out pulse on wrap (WRAP=1 only), registered
//   DONE   out  1          level; count reached zero in one-shot mode
//   BUSY   out  1          high while state == RUN
//   ERR    out  1          sticky; last LOAD contained a non-BCD digit
// BEHAVIOUR
//   - Reset (RST=1 at posedge, any state, mid-count included): DOUT=0, BOUT=0, DONE=0, BUSY=0, ERR=0, state IDLE.
//   - Priority at each edge: RST > LOAD > START > EN.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE  --START, DOUT!=0 or WRAP=1-->  RUN
//     IDLE  --START, DOUT==0, WRAP=0-->    DONE
//     RUN   --EN, DOUT==1, WRAP=0-->       DONE
//     any   --LOAD-->                      IDLE
//   - LOAD, all digits valid: DOUT<=DIN, ERR<=0, DONE<=0, BOUT<=0, state IDLE. Applies even in RUN with EN=1.
//   - LOAD, any digit >9: DOUT unchanged, ERR<=1, state IDLE, DONE<=0.
//   - START is ignored in RUN and DONE. Leaving DONE requires LOAD or RST.
//   - EN is ignored outside RUN.
//   - Decrement, RUN & EN: digit 0 always decrements. Digit k decrements only when digits 0..k-1 are all 0.
//     A digit at 0 that decrements becomes 9. Latency: new DOUT visible the cycle after the EN edge.
//   - One-shot (WRAP=0): DONE rises on the same edge DOUT becomes 0. BUSY falls on that edge.
//     DOUT then holds 0 regardless of EN.
//   - Wrap (WRAP=1): RUN & EN with DOUT==0 gives DOUT<=all 9s and BOUT<=1 for exactly one cycle.
//     BOUT is 0 on every other edge. The counter stays in RUN, and DONE is never asserted.
//   - DONE and BUSY are mutually exclusive. DONE is 0 in IDLE.
// STRUCTURE
//   - Shared package/header: FSM state encodings (S_IDLE, S_RUN, S_DONE), BCD_MAX=4'd9, digit width 4.
//   - Sub-module bcd_down_digit: one-digit register with load, borrow-in (dec enable), and combinational
//     borrow-out (digit==0 & borrow-in). Instantiated DIGITS times via generate, chained digit 0 -> N-1.
//   - Top level holds the FSM, the load validity check, the zero/one detect, and the BOUT/DONE registers.
// TESTING
//   1. DIGITS=2, WRAP=0: LOAD 0x10, START, EN 1 cycle -> DOUT=0x09, BUSY=1, DONE=0.
//   2. LOAD 0x03, START, EN held high -> 0x02, 0x01, 0x00; DONE=1, BUSY=0 on the 0x00 edge; 2 more EN -> 0x00 held.
//   3. WRAP=1: LOAD 0x01, START, EN x2 -> 0x00, then 0x99 with BOUT=1 for one cycle; next EN -> 0x98, BOUT=0.
//   4. LOAD DIN=0x3A -> ERR=1, DOUT unchanged; then LOAD 0x42 -> ERR=0, DOUT=0x42.
//   5. LOAD 0x25, START, 3 EN -> 0x22; RST=1 with EN=1 -> next edge DOUT=0x00, all flags 0, IDLE.
//   6. In RUN, same edge LOAD=1 (DIN=0x57) and EN=1 -> DOUT=0x57, BUSY=0; START with 0x00, WRAP=0 -> DONE=1 next edge.

Source files
------------

// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM states and BCD digit limits.
package bcd_down_timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One BCD digit of the countdown chain: loadable register, decrements on borrow-in,
// borrow-out asserted combinationally when a borrow passes through a zero digit.
module bcd_down_digit
    import bcd_down_timer_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD,
    input  logic [DIGIT_W-1:0] DIN,
    input  logic               BIN,
    output logic [DIGIT_W-1:0] DOUT,
    output logic               BOUT
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT <= '0;
        end else if (LOAD) begin
            DOUT <= DIN;
        end else if (BIN) begin
            DOUT <= (DOUT == '0) ? BCD_MAX : DOUT - 4'd1;
        end
    end

    assign BOUT = BIN && (DOUT == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: one-shot (stops at zero, DONE) or free-running
// (wraps 0..0 -> 9..9 with a one-cycle BOUT pulse).
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LOAD,
    input  logic [4*DIGITS-1:0]     DIN,
    input  logic                    START,
    input  logic                    EN,
    output logic [4*DIGITS-1:0]     DOUT,
    output logic                    BOUT,
    output logic                    DONE,
    output logic                    BUSY,
    output logic                    ERR
);

    localparam int unsigned W = DIGIT_W * DIGITS;

    state_t state, state_n;
    logic   din_ok;
    logic   dout_zero;
    logic   dout_one;
    logic   dec;
    logic [DIGITS:0] borrow;

    always_comb begin
        din_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!digit_ok(DIN[i*DIGIT_W +: DIGIT_W])) begin
                din_ok = 1'b0;
            end
        end
    end

    assign dout_zero = (DOUT == '0);
    assign dout_one  = (DOUT == W'(1));

    // LOAD outranks counting; one-shot mode never decrements past zero.
    assign dec = (state == S_RUN) && EN && !LOAD && !(dout_zero && !WRAP);

    assign borrow[0] = dec;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_down_digit u_digit (
                .CLK  (CLK),
                .RST  (RST),
                .LOAD (LOAD && din_ok),
                .DIN  (DIN[g*DIGIT_W +: DIGIT_W]),
                .BIN  (borrow[g]),
                .DOUT (DOUT[g*DIGIT_W +: DIGIT_W]),
                .BOUT (borrow[g+1])
            );
        end
    endgenerate

    always_comb begin
        state_n = state;
        if (LOAD) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state_n = (dout_zero && !WRAP) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (EN && dout_one && !WRAP) begin
                        state_n = S_DONE;
                    end
                end
                S_DONE:  state_n = S_DONE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // A borrow out of the top digit is exactly the all-zeros wrap event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            BOUT  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_n;
            BOUT  <= WRAP && borrow[DIGITS];
            if (LOAD) begin
                ERR <= !din_ok;
            end
        end
    end

    assign BUSY = (state == S_RUN);
    assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: one-shot and wrapping instances driven in parallel,
// directed scenarios against fixed values plus random traffic against a decimal model.
module tb_bcd_down_timer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, LOAD, START, EN;
    logic [7:0] DIN;

    logic [7:0] dout0, dout1;
    logic       bout0, done0, busy0, err0;
    logic       bout1, done1, busy1, err1;

    bcd_down_timer #(.DIGITS(2), .WRAP(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .DIN(DIN), .START(START), .EN(EN),
        .DOUT(dout0), .BOUT(bout0), .DONE(done0), .BUSY(busy0), .ERR(err0)
    );

    bcd_down_timer #(.DIGITS(2), .WRAP(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .DIN(DIN), .START(START), .EN(EN),
        .DOUT(dout1), .BOUT(bout1), .DONE(done1), .BUSY(busy1), .ERR(err1)
    );

    int total = 0;
    int bad   = 0;

    // Model: index 0 is one-shot, index 1 wraps. Count held as a plain integer 0..99.
    int mval  [2];
    bit mrun  [2];
    bit mdone [2];
    bit merr  [2];
    bit mbout [2];

    function automatic int bcd2int(input logic [7:0] d);
        return int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'(v / 10);
        return r;
    endfunction

    function automatic logic [11:0] exp_vec(input int m);
        return {int2bcd(mval[m]), mbout[m], mdone[m], mrun[m], merr[m]};
    endfunction

    task automatic model_step(input bit r, input bit l, input logic [7:0] d, input bit s, input bit e);
        for (int m = 0; m < 2; m++) begin
            bit w;
            w = (m == 1);
            if (r) begin
                mval[m] = 0; mrun[m] = 0; mdone[m] = 0; merr[m] = 0; mbout[m] = 0;
            end else if (l) begin
                if (d[7:4] <= 4'd9 && d[3:0] <= 4'd9) begin
                    mval[m] = bcd2int(d);
                    merr[m] = 0;
                end else begin
                    merr[m] = 1;
                end
                mrun[m] = 0; mdone[m] = 0; mbout[m] = 0;
            end else begin
                mbout[m] = 0;
                if (s && !mrun[m] && !mdone[m]) begin
                    if (mval[m] == 0 && !w) mdone[m] = 1;
                    else                    mrun[m]  = 1;
                end else if (mrun[m] && e) begin
                    if (mval[m] == 0) begin
                        mval[m]  = 99;
                        mbout[m] = 1;
                    end else begin
                        mval[m] = mval[m] - 1;
                        if (mval[m] == 0 && !w) begin
                            mrun[m]  = 0;
                            mdone[m] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit l, input logic [7:0] d, input bit s, input bit e);
        RST = r; LOAD = l; DIN = d; START = s; EN = e;
        @(posedge CLK);
        model_step(r, l, d, s, e);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 8'h00, 0, 0);
        total++; if ({dout0, bout0, done0, busy0, err0} !== 12'h000) begin bad++; $display("FAIL reset_dut0 got=%h exp=000", {dout0, bout0, done0, busy0, err0}); end
        total++; if ({dout1, bout1, done1, busy1, err1} !== 12'h000) begin bad++; $display("FAIL reset_dut1 got=%h exp=000", {dout1, bout1, done1, busy1, err1}); end
    endtask

    task automatic test_countdown();
        tick(0, 1, 8'h10, 0, 0);
        tick(0, 0, 8'h00, 1, 0);
        tick(0, 0, 8'h00, 0, 1);
        total++; if (dout0 !== 8'h09) begin bad++; $display("FAIL cd_borrow_dout got=%h exp=09", dout0); end
        total++; if ({busy0, done0} !== 2'b10) begin bad++; $display("FAIL cd_borrow_flags got=%b exp=10", {busy0, done0}); end

        tick(0, 1, 8'h03, 0, 0);
        tick(0, 0, 8'h00, 1, 0);
        tick(0, 0, 8'h00, 0, 1);
        total++; if (dout0 !== 8'h02) begin bad++; $display("FAIL cd_02 got=%h exp=02", dout0); end
        tick(0, 0, 8'h00, 0, 1);
        total++; if (dout0 !== 8'h01) begin bad++; $display("FAIL cd_01 got=%h exp=01", dout0); end
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout0, done0, busy0} !== {8'h00, 2'b10}) begin bad++; $display("FAIL cd_zero got=%h exp=%h", {dout0, done0, busy0}, {8'h00, 2'b10}); end
        total++; if ({dout1, done1, busy1} !== {8'h00, 2'b01}) begin bad++; $display("FAIL cd_zero_wrap got=%h exp=%h", {dout1, done1, busy1}, {8'h00, 2'b01}); end
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout0, done0} !== {8'h00, 1'b1}) begin bad++; $display("FAIL cd_hold1 got=%h exp=%h", {dout0, done0}, {8'h00, 1'b1}); end
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout0, done0, busy0} !== {8'h00, 2'b10}) begin bad++; $display("FAIL cd_hold2 got=%h exp=%h", {dout0, done0, busy0}, {8'h00, 2'b10}); end
    endtask

    task automatic test_wrap();
        tick(0, 1, 8'h01, 0, 0);
        tick(0, 0, 8'h00, 1, 0);
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout1, bout1, busy1} !== {8'h00, 2'b01}) begin bad++; $display("FAIL wrap_zero got=%h exp=%h", {dout1, bout1, busy1}, {8'h00, 2'b01}); end
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout1, bout1, done1} !== {8'h99, 2'b10}) begin bad++; $display("FAIL wrap_99 got=%h exp=%h", {dout1, bout1, done1}, {8'h99, 2'b10}); end
        total++; if ({dout0, bout0, done0} !== {8'h00, 2'b01}) begin bad++; $display("FAIL wrap_oneshot_held got=%h exp=%h", {dout0, bout0, done0}, {8'h00, 2'b01}); end
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout1, bout1, busy1} !== {8'h98, 2'b01}) begin bad++; $display("FAIL wrap_98 got=%h exp=%h", {dout1, bout1, busy1}, {8'h98, 2'b01}); end
    endtask

    task automatic test_bad_load();
        tick(0, 1, 8'h3A, 0, 0);
        total++; if ({err0, err1} !== 2'b11) begin bad++; $display("FAIL badload_err got=%b exp=11", {err0, err1}); end
        total++; if ({dout0, dout1} !== 16'h0098) begin bad++; $display("FAIL badload_dout got=%h exp=0098", {dout0, dout1}); end
        total++; if ({done0, busy1} !== 2'b00) begin bad++; $display("FAIL badload_state got=%b exp=00", {done0, busy1}); end
        tick(0, 0, 8'h00, 0, 0);
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL badload_sticky got=%b exp=1", err0); end
        tick(0, 1, 8'h42, 0, 0);
        total++; if ({err0, dout0, dout1} !== {1'b0, 16'h4242}) begin bad++; $display("FAIL goodload got=%h exp=%h", {err0, dout0, dout1}, {1'b0, 16'h4242}); end
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout0, busy0} !== {8'h42, 1'b0}) begin bad++; $display("FAIL idle_en_ignored got=%h exp=%h", {dout0, busy0}, {8'h42, 1'b0}); end
        tick(0, 1, 8'hA5, 0, 0);
        total++; if ({err0, dout0} !== {1'b1, 8'h42}) begin bad++; $display("FAIL badload_top got=%h exp=%h", {err0, dout0}, {1'b1, 8'h42}); end
    endtask

    task automatic test_rst_midcount();
        tick(0, 1, 8'h25, 0, 0);
        tick(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout0, busy0} !== {8'h22, 1'b1}) begin bad++; $display("FAIL rst_pre got=%h exp=%h", {dout0, busy0}, {8'h22, 1'b1}); end
        tick(1, 0, 8'h00, 0, 1);
        total++; if ({dout0, bout0, done0, busy0, err0} !== 12'h000) begin bad++; $display("FAIL rst_mid_dut0 got=%h exp=000", {dout0, bout0, done0, busy0, err0}); end
        total++; if ({dout1, bout1, done1, busy1, err1} !== 12'h000) begin bad++; $display("FAIL rst_mid_dut1 got=%h exp=000", {dout1, bout1, done1, busy1, err1}); end
    endtask

    task automatic test_load_in_run();
        tick(0, 1, 8'h30, 0, 0);
        tick(0, 0, 8'h00, 1, 0);
        tick(0, 0, 8'h00, 0, 1);
        total++; if ({dout0, busy0} !== {8'h29, 1'b1}) begin bad++; $display("FAIL lir_29 got=%h exp=%h", {dout0, busy0}, {8'h29, 1'b1}); end
        tick(0, 1, 8'h57, 0, 1);
        total++; if ({dout0, busy0, dout1, busy1} !== {8'h57, 1'b0, 8'h57, 1'b0}) begin bad++; $display("FAIL lir_load got=%h exp=%h", {dout0, busy0, dout1, busy1}, {8'h57, 1'b0, 8'h57, 1'b0}); end
        tick(0, 1, 8'h00, 0, 0);
        tick(0, 0, 8'h00, 1, 0);
        total++; if ({done0, busy0} !== 2'b10) begin bad++; $display("FAIL lir_start_zero got=%b exp=10", {done0, busy0}); end
        total++; if ({done1, busy1} !== 2'b01) begin bad++; $display("FAIL lir_start_zero_wrap got=%b exp=01", {done1, busy1}); end
        tick(0, 0, 8'h00, 1, 1);
        total++; if ({dout0, done0, busy0} !== {8'h00, 2'b10}) begin bad++; $display("FAIL lir_done_sticky got=%h exp=%h", {dout0, done0, busy0}, {8'h00, 2'b10}); end
        total++; if ({dout1, bout1} !== {8'h99, 1'b1}) begin bad++; $display("FAIL lir_wrap_from_zero got=%h exp=%h", {dout1, bout1}, {8'h99, 1'b1}); end
    endtask

    task automatic test_random();
        bit         r, l, s, e;
        logic [7:0] d;
        logic [11:0] act;
        for (int c = 0; c < 1200; c++) begin
            r = ($urandom % 80 == 0);
            l = ($urandom % 14 == 0);
            d = ($urandom % 2 == 0) ? {4'($urandom % 10), 4'($urandom % 10)} : 8'($urandom);
            s = ($urandom % 6 == 0);
            e = ($urandom % 4 != 0);
            tick(r, l, d, s, e);
            for (int m = 0; m < 2; m++) begin
                act = (m == 0) ? {dout0, bout0, done0, busy0, err0} : {dout1, bout1, done1, busy1, err1};
                total++;
                if (act !== exp_vec(m)) begin
                    bad++;
                    $display("FAIL rand_dut%0d cycle=%0d got=%h exp=%h (dout,bout,done,busy,err)", m, c, act, exp_vec(m));
                end
            end
        end
    endtask

    initial begin
        RST = 1'b0; LOAD = 1'b0; START = 1'b0; EN = 1'b0; DIN = 8'h00;
        for (int m = 0; m < 2; m++) begin
            mval[m] = 0; mrun[m] = 0; mdone[m] = 0; merr[m] = 0; mbout[m] = 0;
        end
        test_reset();
        test_countdown();
        test_wrap();
        test_bad_load();
        test_rst_midcount();
        test_load_in_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
